dispatch_credit_ctrl: RTL and testbench

Credit-based dispatch controller between the instruction fetcher and the ROB, RS and LSB. It tracks occupancy of all three structures, allocates ROB tags in order, and back-pressures the fetcher. It fires the per-unit enable pulses only when the target structures have a free slot. It makes dispatch safe without the downstream units signalling "full", and it clears all credits on a pipeline flush.

---
 rtl/dispatch_credit_ctrl.sv | 124 ++++++++++++
 tb/tb_dispatch_credit_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_credit_ctrl.sv
// Credit-based dispatch controller: tracks ROB/RS/LSB occupancy, hands out ROB tags
// in order and gates fetcher dispatch so no downstream structure can overflow.
module dispatch_credit_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int RS_DEPTH  = 16,
  parameter int LSB_DEPTH = 16,
  parameter int TAG_W     = 4,
  parameter int RS_CW     = $clog2(RS_DEPTH + 1),
  parameter int LSB_CW    = $clog2(LSB_DEPTH + 1),
  parameter logic [5:0] OP_LB = 6'd11,
  parameter logic [5:0] OP_SW = 6'd18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              ifetch_valid,
  input  logic [5:0]        ifetch_optype,
  output logic              ifetch_ready,
  output logic              rob_enable,
  output logic              rename_enable,
  output logic              rs_enable,
  output logic              lsb_enable,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              rob_commit,
  input  logic              rs_release,
  input  logic              lsb_release,
  output logic [TAG_W:0]    rob_count,
  output logic [RS_CW-1:0]  rs_count,
  output logic [LSB_CW-1:0] lsb_count,
  output logic              credit_err
);

  localparam logic [TAG_W:0]    ROB_FULL = (TAG_W + 1)'(ROB_DEPTH);
  localparam logic [RS_CW-1:0]  RS_FULL  = RS_CW'(RS_DEPTH);
  localparam logic [LSB_CW-1:0] LSB_FULL = LSB_CW'(LSB_DEPTH);

  logic [TAG_W-1:0] rob_head;
  logic [TAG_W-1:0] rob_tail;

  logic is_ls;
  logic room;
  logic fire;
  logic advance;
  logic rs_fire;
  logic lsb_fire;
  logic commit_ok;
  logic rs_rel_ok;
  logic lsb_rel_ok;
  logic bad_release;

  assign is_ls = (ifetch_optype >= OP_LB) && (ifetch_optype <= OP_SW);
  assign room  = (rob_count != ROB_FULL) &&
                 (is_ls ? (lsb_count != LSB_FULL) : (rs_count != RS_FULL));

  assign ifetch_ready = rst_n && rdy && !flush && room;
  assign fire         = ifetch_valid && ifetch_ready;
  assign rs_fire      = fire && !is_ls;
  assign lsb_fire     = fire && is_ls;

  assign rob_enable    = fire;
  assign rename_enable = fire;
  assign rs_enable     = rs_fire;
  assign lsb_enable    = lsb_fire;
  assign issue_tag     = rob_tail;

  assign advance = rdy && !flush;

  // A same-cycle fire on the structure nets against the release, so an empty
  // count is not an underflow in that case.
  assign commit_ok  = rob_commit  && ((rob_count != '0) || fire);
  assign rs_rel_ok  = rs_release  && ((rs_count  != '0) || rs_fire);
  assign lsb_rel_ok = lsb_release && ((lsb_count != '0) || lsb_fire);

  assign bad_release = (rob_commit  && !commit_ok) ||
                       (rs_release  && !rs_rel_ok) ||
                       (lsb_release && !lsb_rel_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rob_head   <= '0;
      rob_tail   <= '0;
      rob_count  <= '0;
      rs_count   <= '0;
      lsb_count  <= '0;
      credit_err <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        rob_head  <= '0;
        rob_tail  <= '0;
        rob_count <= '0;
        rs_count  <= '0;
        lsb_count <= '0;
      end else begin
        if (fire)      rob_tail <= rob_tail + 1'b1;
        if (commit_ok) rob_head <= rob_head + 1'b1;

        unique case ({fire, commit_ok})
          2'b10:   rob_count <= rob_count + 1'b1;
          2'b01:   rob_count <= rob_count - 1'b1;
          default: rob_count <= rob_count;
        endcase

        unique case ({rs_fire, rs_rel_ok})
          2'b10:   rs_count <= rs_count + 1'b1;
          2'b01:   rs_count <= rs_count - 1'b1;
          default: rs_count <= rs_count;
        endcase

        unique case ({lsb_fire, lsb_rel_ok})
          2'b10:   lsb_count <= lsb_count + 1'b1;
          2'b01:   lsb_count <= lsb_count - 1'b1;
          default: lsb_count <= lsb_count;
        endcase

        if (bad_release) credit_err <= 1'b1;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = advance;

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// Directed bench for dispatch_credit_ctrl; dispatch pulses are checked against
// an expected-tag queue by a separate monitor, occupancy by direct compares.
module tb_dispatch_credit_ctrl;

  localparam logic [5:0] OP_LW  = 6'd13;
  localparam logic [5:0] OP_SW  = 6'd18;
  localparam logic [5:0] OP_ADD = 6'd28;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy;
  logic       flush;
  logic       ifetch_valid;
  logic [5:0] ifetch_optype;
  logic       ifetch_ready;
  logic       rob_enable;
  logic       rename_enable;
  logic       rs_enable;
  logic       lsb_enable;
  logic [3:0] issue_tag;
  logic       rob_commit;
  logic       rs_release;
  logic       lsb_release;
  logic [4:0] rob_count;
  logic [4:0] rs_count;
  logic [4:0] lsb_count;
  logic       credit_err;

  typedef struct packed {
    logic [3:0] tag;
    logic       ls;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dispatch_credit_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rdy           (rdy),
    .flush         (flush),
    .ifetch_valid  (ifetch_valid),
    .ifetch_optype (ifetch_optype),
    .ifetch_ready  (ifetch_ready),
    .rob_enable    (rob_enable),
    .rename_enable (rename_enable),
    .rs_enable     (rs_enable),
    .lsb_enable    (lsb_enable),
    .issue_tag     (issue_tag),
    .rob_commit    (rob_commit),
    .rs_release    (rs_release),
    .lsb_release   (lsb_release),
    .rob_count     (rob_count),
    .rs_count      (rs_count),
    .lsb_count     (lsb_count),
    .credit_err    (credit_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fire(input int tag, input logic ls);
    exp_t e;
    e.tag = tag[3:0];
    e.ls  = ls;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rob_enable || rename_enable || rs_enable || lsb_enable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fire tag=%0d rs=%0b lsb=%0b", issue_tag, rs_enable, lsb_enable);
        end else begin
          e = exp_q.pop_front();
          chk("fire_tag", issue_tag, e.tag);
          chk("fire_lsb_en", lsb_enable, e.ls);
          chk("fire_rs_en", rs_enable, !e.ls);
          chk("fire_rename_en", {rob_enable, rename_enable}, 3);
        end
      end
    end
  endtask

  task automatic flush_cycle();
    ifetch_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
    ifetch_valid = 1'b0; ifetch_optype = OP_ADD;
    rob_commit = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
    fork
      monitor();
    join_none

    // Reset: no ready even with a valid instruction presented.
    ifetch_valid = 1'b1;
    #12;
    chk("rst_ready", ifetch_ready, 0);
    chk("rst_rob_en", rob_enable, 0);
    chk("rst_rob_count", rob_count, 0);
    chk("rst_credit_err", credit_err, 0);
    ifetch_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Three ALU dispatches, then two more for the flush scenario.
    for (int i = 0; i < 5; i++) begin
      ifetch_valid = 1'b1; ifetch_optype = OP_ADD;
      expect_fire(i, 1'b0);
      #1 chk("alu_ready", ifetch_ready, 1);
      cyc();
      if (i == 2) begin
        ifetch_valid = 1'b0;
        #1;
        chk("alu3_rob_count", rob_count, 3);
        chk("alu3_rs_count", rs_count, 3);
        chk("alu3_lsb_count", lsb_count, 0);
        chk("alu3_tag", issue_tag, 3);
      end
    end

    // Flush with 5 in flight and a valid instruction presented.
    ifetch_valid = 1'b1; ifetch_optype = OP_ADD; flush = 1'b1;
    #1;
    chk("flush_rob_en", rob_enable, 0);
    chk("flush_ready", ifetch_ready, 0);
    cyc();
    flush = 1'b0; ifetch_valid = 1'b0;
    #1;
    chk("post_flush_rob", rob_count, 0);
    chk("post_flush_rs", rs_count, 0);
    chk("post_flush_tag", issue_tag, 0);

    // Fill LSB (and ROB) with 16 loads.
    for (int i = 0; i < 16; i++) begin
      ifetch_valid = 1'b1; ifetch_optype = OP_LW;
      expect_fire(i, 1'b1);
      cyc();
    end
    ifetch_optype = OP_SW;
    #1;
    chk("lsb_full_ready", ifetch_ready, 0);
    chk("lsb_full_lsb_en", lsb_enable, 0);
    chk("lsb_full_rob", rob_count, 16);
    chk("lsb_full_lsb", lsb_count, 16);
    ifetch_valid = 1'b0; rob_commit = 1'b1;
    cyc();
    rob_commit = 1'b0;
    #1 chk("commit_rob", rob_count, 15);
    ifetch_valid = 1'b1; ifetch_optype = OP_SW;
    #1;
    chk("sw_blocked_ready", ifetch_ready, 0);
    chk("sw_blocked_lsb_en", lsb_enable, 0);
    ifetch_optype = OP_ADD;
    expect_fire(0, 1'b0);
    #1 chk("add_ready_lsb_full", ifetch_ready, 1);
    cyc();
    ifetch_valid = 1'b0;
    #1;
    chk("wrap_rob_count", rob_count, 16);
    chk("wrap_rob_head", dut.rob_head, 1);
    chk("wrap_rs_count", rs_count, 1);
    chk("wrap_tag", issue_tag, 1);
    flush_cycle();

    // Fill RS, free one ROB slot so only RS blocks.
    for (int i = 0; i < 16; i++) begin
      ifetch_valid = 1'b1; ifetch_optype = OP_ADD;
      expect_fire(i, 1'b0);
      cyc();
    end
    ifetch_valid = 1'b0; rob_commit = 1'b1;
    cyc();
    rob_commit = 1'b0;
    ifetch_valid = 1'b1; rs_release = 1'b1;
    #1;
    chk("rs_full_ready", ifetch_ready, 0);
    chk("rs_full_rs_en", rs_enable, 0);
    cyc();
    rs_release = 1'b0;
    #1;
    chk("rs_after_rel", rs_count, 15);
    chk("rs_after_rel_ready", ifetch_ready, 1);
    expect_fire(0, 1'b0);
    cyc();
    ifetch_valid = 1'b0;
    #1;
    chk("rs_refill", rs_count, 16);
    chk("rob_refill", rob_count, 16);
    flush_cycle();

    // Underflow release sets the sticky error.
    lsb_release = 1'b1;
    cyc();
    lsb_release = 1'b0;
    #1;
    chk("err_set", credit_err, 1);
    chk("err_lsb_count", lsb_count, 0);
    repeat (3) cyc();
    chk("err_sticky", credit_err, 1);

    // Freeze with rdy low.
    for (int i = 0; i < 2; i++) begin
      ifetch_valid = 1'b1; ifetch_optype = OP_ADD;
      expect_fire(i, 1'b0);
      cyc();
    end
    rdy = 1'b0; rob_commit = 1'b1; rs_release = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("freeze_ready", ifetch_ready, 0);
      chk("freeze_rob_en", rob_enable, 0);
      cyc();
    end
    rdy = 1'b1; ifetch_valid = 1'b0; rob_commit = 1'b0; rs_release = 1'b0;
    #1;
    chk("freeze_rob_count", rob_count, 2);
    chk("freeze_rs_count", rs_count, 2);
    chk("freeze_tag", issue_tag, 2);
    chk("freeze_err", credit_err, 1);

    // Asynchronous reset mid-cycle.
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_rob", rob_count, 0);
    chk("async_rst_rs", rs_count, 0);
    chk("async_rst_tag", issue_tag, 0);
    chk("async_rst_err", credit_err, 0);
    rst_n = 1'b1;
    cyc();
    chk("pending_expected", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
